// File: rtl/fwd_bypass_net.sv
// fwd_bypass_net
// Result-staging and operand forwarding network for the SPU datapath.
// Each issue lane pushes a result packet (rt, value, lat) that shifts through
// DEPTH stages. Every operand read port is given the youngest matching
// in-flight value if it is ready. If the youngest match is not yet ready, a
// hazard is raised instead. The last stage is registered out as RF writeback.
//
// Optional build macro: FWD_SAME_CYCLE_EN
//   When defined, this cycle's pushes join the forwarding search as the
//   youngest level, ahead of stage 1. When undefined, pushes become visible
//   only from stage 1 onward.
module fwd_bypass_net #(
  parameter int NUM_PIPES   = 2,
  parameter int DEPTH       = 7,
  parameter int NUM_SRC     = 5,
  parameter int AW          = 7,
  parameter int DW          = 128,
  parameter int LW          = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_PIPES-1:0]                   in_valid,
  input  logic [NUM_PIPES*AW-1:0]                in_rt,
  input  logic [NUM_PIPES*DW-1:0]                in_value,
  input  logic [NUM_PIPES*LW-1:0]                in_lat,
  input  logic                                   flush,
  input  logic [NUM_SRC*AW-1:0]                  src_addr,
  input  logic [NUM_SRC*DW-1:0]                  src_rf_value,
  output logic [NUM_SRC*DW-1:0]                  src_value,
  output logic [NUM_SRC-1:0]                     src_hazard,
  output logic [NUM_PIPES-1:0]                   wb_valid,
  output logic [NUM_PIPES*AW-1:0]                wb_rt,
  output logic [NUM_PIPES*DW-1:0]                wb_value,
  output logic [$clog2(NUM_PIPES*DEPTH+1)-1:0]   inflight_cnt
);

  localparam int CW = $clog2(NUM_PIPES*DEPTH+1);

  // Latency 0 means "ready immediately" (stage 1); anything past the last
  // stage is ready at the last stage so it still forwards before leaving.
  function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
    if (lat == '0)
      return LW'(1);
    if (32'(lat) > DEPTH)
      return LW'(DEPTH);
    return lat;
  endfunction

  // A packet sitting in 1-based stage 'stage' is ready once stage >= lat.
  function automatic logic ready_at(input int stage, input logic [LW-1:0] lat);
    return LW'(stage) >= lat;
  endfunction

  // Flush kills sources 0..FLUSH_DEPTH, where source 0 is the incoming push
  // and source k is the packet currently held in stage k.
  function automatic logic kill_src(input int k, input logic fl);
    return fl && (FLUSH_DEPTH > 0) && (k <= FLUSH_DEPTH);
  endfunction

  // Stage state: index k holds stage k+1.
  logic [NUM_PIPES-1:0] vld_p     [DEPTH];
  logic [AW-1:0]        rt_p      [DEPTH][NUM_PIPES];
  logic [DW-1:0]        val_p     [DEPTH][NUM_PIPES];
  logic [LW-1:0]        lat_p     [DEPTH][NUM_PIPES];

  logic [NUM_PIPES-1:0] vld_p_nxt [DEPTH];
  logic [NUM_PIPES-1:0] wb_vld_nxt;
  logic [CW-1:0]        cnt_nxt;
  logic [LW-1:0]        in_lat_c  [NUM_PIPES];

  // Normalise the incoming latency field per lane.
  always_comb begin
    for (int p = 0; p < NUM_PIPES; p++)
      in_lat_c[p] = clamp_lat(in_lat[p*LW +: LW]);
  end

  // Next-state valid bits: unconditional shift, with flush killing the young end.
  always_comb begin
    for (int k = 0; k < DEPTH; k++)
      vld_p_nxt[k] = '0;
    vld_p_nxt[0] = kill_src(0, flush) ? '0 : in_valid;
    for (int k = 1; k < DEPTH; k++)
      vld_p_nxt[k] = kill_src(k, flush) ? '0 : vld_p[k-1];
    wb_vld_nxt = kill_src(DEPTH, flush) ? '0 : vld_p[DEPTH-1];
  end

  // Population count of the packets that will occupy stages after this edge.
  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++)
      for (int p = 0; p < NUM_PIPES; p++)
        cnt_nxt = cnt_nxt + CW'(vld_p_nxt[k][p]);
  end

  // ---- stage boundary: push -> stage 1 -> ... -> stage DEPTH (control) ----
  // Valid bits and occupancy count; these are the only reset stage state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++)
        vld_p[k] <= '0;
      inflight_cnt <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++)
        vld_p[k] <= vld_p_nxt[k];
      inflight_cnt <= cnt_nxt;
    end
  end

  // ---- stage boundary: push -> stage 1 -> ... -> stage DEPTH (data) ----
  // Payload shifts every cycle; contents are meaningless while valid is low.
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PIPES; p++) begin
      rt_p[0][p]  <= in_rt[p*AW +: AW];
      val_p[0][p] <= in_value[p*DW +: DW];
      lat_p[0][p] <= in_lat_c[p];
      for (int k = 1; k < DEPTH; k++) begin
        rt_p[k][p]  <= rt_p[k-1][p];
        val_p[k][p] <= val_p[k-1][p];
        lat_p[k][p] <= lat_p[k-1][p];
      end
    end
  end

  // ---- stage boundary: stage DEPTH -> writeback ----
  // Writeback strobe every cycle; address/data only load on a valid packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid <= '0;
      wb_rt    <= '0;
      wb_value <= '0;
    end else begin
      wb_valid <= wb_vld_nxt;
      for (int p = 0; p < NUM_PIPES; p++) begin
        if (wb_vld_nxt[p]) begin
          wb_rt[p*AW +: AW]    <= rt_p[DEPTH-1][p];
          wb_value[p*DW +: DW] <= val_p[DEPTH-1][p];
        end
      end
    end
  end

  // Per-port youngest-match search. Scan from oldest to youngest so the last
  // hit wins: larger stage first, then within a stage lower lane first.
  always_comb begin
    logic          hit;
    logic          rdy;
    logic [DW-1:0] hv;
    logic [AW-1:0] addr;
    src_value  = '0;
    src_hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit  = 1'b0;
      rdy  = 1'b0;
      hv   = '0;
      addr = src_addr[i*AW +: AW];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        for (int p = 0; p < NUM_PIPES; p++) begin
          if (vld_p[k][p] && (rt_p[k][p] == addr)) begin
            hit = 1'b1;
            rdy = ready_at(k + 1, lat_p[k][p]);
            hv  = val_p[k][p];
          end
        end
      end
`ifdef FWD_SAME_CYCLE_EN
      for (int p = 0; p < NUM_PIPES; p++) begin
        if (in_valid[p] && !kill_src(0, flush) && (in_rt[p*AW +: AW] == addr)) begin
          hit = 1'b1;
          rdy = (in_lat_c[p] == LW'(1));
          hv  = in_value[p*DW +: DW];
        end
      end
`endif
      src_hazard[i]         = hit && !rdy;
      src_value[i*DW +: DW] = (hit && rdy) ? hv : src_rf_value[i*DW +: DW];
    end
  end

endmodule
